// File: rtl/cp0_register_file.sv
// -----------------------------------------------------------------------------
// cp0_register_file
//
// CP0 system-control register file for the MIPS core. It sits beside the
// writeback stage and provides these registers: Index, EntryLo0/1, BadVAddr,
// Count, EntryHi, Compare, Status, Cause and EPC. It also contains the Count
// timer, the interrupt-pending logic and the exception/eret commit logic.
//
// Ports
//   clock, reset_n          core clock, asynchronous active-low reset
//   mtc0_en/addr/data       register write; addr = {rd[4:0], sel[2:0]}
//   mfc0_addr/data          combinational register read; unimplemented -> 0
//   exc_valid, exc_code, exc_bd, exc_pc,
//   exc_badvaddr_en, exc_badvaddr, exc_refill
//                           exception commit and vector selection
//   eret                    exception return (clears EXL)
//   tlbp_en/miss/index      TLB probe result into Index
//   tlbr_en/hi/lo0/lo1      TLB read result into EntryHi/EntryLo0/EntryLo1
//   hw_int                  level hardware interrupt lines
//   exc_target              exception vector (combinational)
//   epc                     return address for eret
//   int_pending             registered interrupt request to fetch
//   entry_hi, entry_lo0, entry_lo1, index
//                           current TLB-facing register values
// -----------------------------------------------------------------------------
module cp0_register_file #(
   parameter int TLB_NUM    = 16,
   parameter int HW_INT_NUM = 6,
   parameter int COUNT_DIV  = 2,
   parameter int TIMER_LINE = 5
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       mtc0_en,
   input  logic [7:0]                 mtc0_addr,
   input  logic [31:0]                mtc0_data,
   input  logic [7:0]                 mfc0_addr,
   output logic [31:0]                mfc0_data,
   input  logic                       exc_valid,
   input  logic [4:0]                 exc_code,
   input  logic                       exc_bd,
   input  logic [31:0]                exc_pc,
   input  logic                       exc_badvaddr_en,
   input  logic [31:0]                exc_badvaddr,
   input  logic                       exc_refill,
   input  logic                       eret,
   input  logic                       tlbp_en,
   input  logic                       tlbp_miss,
   input  logic [$clog2(TLB_NUM)-1:0] tlbp_index,
   input  logic                       tlbr_en,
   input  logic [31:0]                tlbr_hi,
   input  logic [31:0]                tlbr_lo0,
   input  logic [31:0]                tlbr_lo1,
   input  logic [HW_INT_NUM-1:0]      hw_int,
   output logic [31:0]                exc_target,
   output logic [31:0]                epc,
   output logic                       int_pending,
   output logic [31:0]                entry_hi,
   output logic [31:0]                entry_lo0,
   output logic [31:0]                entry_lo1,
   output logic [31:0]                index
);

   localparam int IW = $clog2(TLB_NUM);
   localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

   // Register addresses, {rd, sel}
   localparam logic [7:0] A_INDEX    = 8'h00;
   localparam logic [7:0] A_LO0      = 8'h10;
   localparam logic [7:0] A_LO1      = 8'h18;
   localparam logic [7:0] A_BADVADDR = 8'h40;
   localparam logic [7:0] A_COUNT    = 8'h48;
   localparam logic [7:0] A_HI       = 8'h50;
   localparam logic [7:0] A_COMPARE  = 8'h58;
   localparam logic [7:0] A_STATUS   = 8'h60;
   localparam logic [7:0] A_CAUSE    = 8'h68;
   localparam logic [7:0] A_EPC      = 8'h70;

   // EntryLo keeps PFN/C/D/V/G; EntryHi keeps VPN2 and ASID
   localparam logic [31:0] LO_MASK = 32'h03FF_FFFF;
   localparam logic [31:0] HI_MASK = 32'hFFFF_E0FF;

   // Architectural state (_q) and next state (_d)
   logic                  idx_p_q, idx_p_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [31:0]           lo0_q, lo0_d, lo1_q, lo1_d, hi_q, hi_d;
   logic [31:0]           badvaddr_q, badvaddr_d, epc_q, epc_d;
   logic [31:0]           count_q, count_d, compare_q, compare_d;
   logic                  bev_q;
   logic [7:0]            im_q, im_d;
   logic                  exl_q, exl_d, ie_q, ie_d;
   logic                  bd_q, bd_d, ti_q, ti_d;
   logic [1:0]            ip_sw_q, ip_sw_d;
   logic [4:0]            exc_code_q, exc_code_d;
   logic [HW_INT_NUM-1:0] hw_int_q;
   logic [DW-1:0]         div_q, div_d;
   logic                  int_pending_q, int_pending_d;

   logic       div_wrap, count_wr, compare_wr;
   logic [5:0] ip_hw;
   logic [7:0] ip;

   assign div_wrap   = (div_q == DW'(COUNT_DIV - 1));
   assign count_wr   = mtc0_en && (mtc0_addr == A_COUNT);
   assign compare_wr = mtc0_en && (mtc0_addr == A_COMPARE);

   // Cause.IP[7:2]: registered hardware lines, with the timer folded onto one line
   always_comb begin
      ip_hw                 = '0;
      ip_hw[HW_INT_NUM-1:0] = hw_int_q;
      ip_hw[TIMER_LINE]     = ip_hw[TIMER_LINE] | ti_q;
      ip                    = {ip_hw, ip_sw_q};
   end

   // Next-state logic
   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
      idx_p_d       = idx_p_q;
      idx_d         = idx_q;
      lo0_d         = lo0_q;
      lo1_d         = lo1_q;
      hi_d          = hi_q;
      badvaddr_d    = badvaddr_q;
      epc_d         = epc_q;
      compare_d     = compare_q;
      im_d          = im_q;
      exl_d         = exl_q;
      ie_d          = ie_q;
      bd_d          = bd_q;
      ti_d          = ti_q;
      ip_sw_d       = ip_sw_q;
      exc_code_d    = exc_code_q;
      int_pending_d = ie_q && !exl_q && ((im_q & ip) != 8'h00);

      // NOTE: writers are applied lowest priority first; a later assignment to the
      // same field overrides the earlier one, which is what drops the weaker write.
      if (mtc0_en) begin
         case (mtc0_addr)
            A_INDEX:   idx_d     = mtc0_data[IW-1:0];
            A_LO0:     lo0_d     = mtc0_data & LO_MASK;
            A_LO1:     lo1_d     = mtc0_data & LO_MASK;
            A_HI:      hi_d      = mtc0_data & HI_MASK;
            A_COMPARE: compare_d = mtc0_data;
            A_STATUS: begin
               im_d  = mtc0_data[15:8];
               exl_d = mtc0_data[1];
               ie_d  = mtc0_data[0];
            end
            A_CAUSE:   ip_sw_d   = mtc0_data[9:8];
            default: ;
         endcase
      end

      // A Count write restarts the divider and replaces this cycle's increment
      if (count_wr) begin
         count_d = mtc0_data;
         div_d   = '0;
      end else begin
         count_d = count_q + {31'b0, div_wrap};
         div_d   = div_wrap ? '0 : div_q + DW'(1);
      end

      // Timer match only on an edge where Count changes; a Compare write wins
      if (compare_wr)
         ti_d = 1'b0;
      else if ((count_wr || div_wrap) && (count_d == compare_q))
         ti_d = 1'b1;

      if (tlbp_en) begin
         idx_p_d = tlbp_miss;
         idx_d   = tlbp_index;
      end
      if (tlbr_en) begin
         hi_d  = tlbr_hi  & HI_MASK;
         lo0_d = tlbr_lo0 & LO_MASK;
         lo1_d = tlbr_lo1 & LO_MASK;
      end

      if (eret)
         exl_d = 1'b0;

      if (exc_valid) begin
         // A nested exception keeps the original return point
         if (!exl_q) begin
            epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
            bd_d  = exc_bd;
         end
         exl_d      = 1'b1;
         exc_code_d = exc_code;
         if (exc_badvaddr_en)
            badvaddr_d = exc_badvaddr;
      end
   end

   // State registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         idx_p_q       <= 1'b0;
         idx_q         <= '0;
         lo0_q         <= '0;
         lo1_q         <= '0;
         hi_q          <= '0;
         badvaddr_q    <= '0;
         epc_q         <= '0;
         count_q       <= '0;
         compare_q     <= '0;
         bev_q         <= 1'b1;
         im_q          <= '0;
         exl_q         <= 1'b0;
         ie_q          <= 1'b0;
         bd_q          <= 1'b0;
         ti_q          <= 1'b0;
         ip_sw_q       <= '0;
         exc_code_q    <= '0;
         hw_int_q      <= '0;
         div_q         <= '0;
         int_pending_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         idx_p_q       <= idx_p_d;
         idx_q         <= idx_d;
         lo0_q         <= lo0_d;
         lo1_q         <= lo1_d;
         hi_q          <= hi_d;
         badvaddr_q    <= badvaddr_d;
         epc_q         <= epc_d;
         count_q       <= count_d;
         compare_q     <= compare_d;
         bev_q         <= bev_q;          // BEV is not software-writable
         im_q          <= im_d;
         exl_q         <= exl_d;
         ie_q          <= ie_d;
         bd_q          <= bd_d;
         ti_q          <= ti_d;
         ip_sw_q       <= ip_sw_d;
         exc_code_q    <= exc_code_d;
         hw_int_q      <= hw_int;
         div_q         <= div_d;
         int_pending_q <= int_pending_d;
      end
   end

   // Outputs
   assign index       = {idx_p_q, {(31 - IW){1'b0}}, idx_q};
   assign entry_hi    = hi_q;
   assign entry_lo0   = lo0_q;
   assign entry_lo1   = lo1_q;
   assign epc         = epc_q;
   assign int_pending = int_pending_q;
   assign exc_target  = (bev_q ? 32'hBFC0_0200 : 32'h8000_0000) +
                        ((exc_refill && !exl_q) ? 32'h0000_0000 : 32'h0000_0180);

   always_comb begin
      mfc0_data = '0;
      case (mfc0_addr)
         A_INDEX:    mfc0_data = index;
         A_LO0:      mfc0_data = lo0_q;
         A_LO1:      mfc0_data = lo1_q;
         A_BADVADDR: mfc0_data = badvaddr_q;
         A_COUNT:    mfc0_data = count_q;
         A_HI:       mfc0_data = hi_q;
         A_COMPARE:  mfc0_data = compare_q;
         A_STATUS:   mfc0_data = {9'b0, bev_q, 6'b0, im_q, 6'b0, exl_q, ie_q};
         A_CAUSE:    mfc0_data = {bd_q, ti_q, 14'b0, ip, 1'b0, exc_code_q, 2'b0};
         A_EPC:      mfc0_data = epc_q;
         default: ;
      endcase
   end

endmodule
